// File: rtl/dma_copy_pkg.sv
// Shared types and constants for the memory-to-memory copy master.
package dma_copy_pkg;

    localparam int unsigned DMA_ADDR_W = 17;
    localparam int unsigned DMA_DATA_W = 32;
    localparam int unsigned DMA_DEPTH  = 102400;

    localparam logic [3:0] DMA_BYTEEN = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StDone
    } dma_state_e;

endpackage

// File: rtl/dma_mm_copy_master.sv
// Avalon-MM master copying words within a single-port RAM (read latency 1).
// Each word takes three cycles: read address, capture into the holding
// register, write. Bus outputs are registered from the next-state decode.
module dma_mm_copy_master
    import dma_copy_pkg::*;
#(
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned DATA_W = DMA_DATA_W,
    parameter int unsigned DEPTH  = DMA_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              avm_clken
);

    localparam logic [ADDR_W+1:0] DepthExt = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

    dma_state_e state_q, state_d;

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] hold_q;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W+1:0] src_end;
    logic [ADDR_W+1:0] dst_end;
    logic              reject;

    // Two extra bits so the end address cannot overflow before comparison.
    assign src_end = {2'b00, src_addr} + {1'b0, length};
    assign dst_end = {2'b00, dst_addr} + {1'b0, length};
    assign reject  = (src_end > DepthExt) || (dst_end > DepthExt);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (reject || (length == '0)) ? StDone : StRd;
                end
            end
            StRd:    state_d = StCap;
            StCap:   state_d = StWr;
            StWr:    state_d = (len_q == LenOne) ? StDone : StRd;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch and per-word address/length stepping.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        if ((state_q == StIdle) && start) begin
            src_d = src_addr;
            dst_d = dst_addr;
            len_d = length;
        end else if (state_q == StWr) begin
            src_d = src_q + AddrOne;
            dst_d = dst_q + AddrOne;
            len_d = len_q - LenOne;
        end
    end

    // Bus and status outputs for the upcoming state; address uses stepped counters.
    always_comb begin
        addr_d = addr_q;
        cs_d   = 1'b0;
        we_d   = 1'b0;
        be_d   = 4'h0;
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (state_d)
            StRd: begin
                cs_d   = 1'b1;
                addr_d = src_d;
            end
            StWr: begin
                cs_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = dst_d;
                be_d   = DMA_BYTEEN;
            end
            StDone: begin
                done_d = 1'b1;
                // Only a command rejected straight out of idle reports an error.
                err_d  = (state_q == StIdle) && reject;
            end
            default: ;
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            hold_q <= '0;
            addr_q <= '0;
            cs_q   <= 1'b0;
            we_q   <= 1'b0;
            be_q   <= 4'h0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            if (state_q == StCap) begin
                hold_q <= avm_readdata;
            end
            addr_q <= addr_d;
            cs_q   <= cs_d;
            we_q   <= we_d;
            be_q   <= be_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign err            = err_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = we_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = hold_q;
    assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_dma_mm_copy_master.sv
// Directed bench for dma_mm_copy_master with a behavioural latency-1 RAM.
module tb_dma_mm_copy_master;
    import dma_copy_pkg::*;

    localparam int unsigned AW    = DMA_ADDR_W;
    localparam int unsigned DW    = DMA_DATA_W;
    localparam int unsigned DEPTH = DMA_DEPTH;

    typedef struct {
        string         name;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        int            exp_done;
        logic          exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write;
    logic [3:0]    avm_byteenable;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_clken;

    logic [DW-1:0] mem     [0:DEPTH-1];
    bit            written [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dma_mm_copy_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_clken      (avm_clken)
    );

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        return 32'h5A00_0000 ^ DW'(a);
    endfunction

    function automatic logic [DW-1:0] mem_word(input int unsigned a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port RAM: registered read data, byte-enabled writes, bench preload port.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr]     <= ld_data;
            written[ld_addr] <= 1'b1;
        end else if (avm_clken && avm_chipselect && (int'(avm_address) < DEPTH)) begin
            if (avm_write) begin
                mem[avm_address]     <= merge(mem_word(avm_address), avm_writedata,
                                              avm_byteenable);
                written[avm_address] <= 1'b1;
            end else begin
                avm_readdata <= mem_word(avm_address);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int unsigned a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic ref_copy(input int unsigned s, input int unsigned d, input int unsigned n);
        for (int k = 0; k < int'(n); k++) ref_mem[d + k] = ref_mem[s + k];
    endtask

    task automatic mem_compare(input string n);
        int bad;
        bad = 0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (mem_word(a) !== ref_mem[a]) bad++;
        end
        check({n, "_mem_image"}, 64'(bad), 64'd0);
    endtask

    task automatic add_vec(input string n, input int unsigned s, input int unsigned d,
                           input int unsigned l, input int ed, input logic ee);
        vec_t v;
        v.name     = n;
        v.src      = AW'(s);
        v.dst      = AW'(d);
        v.len      = (AW + 1)'(l);
        v.exp_done = ed;
        v.exp_err  = ee;
        vq.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int            ndone, done_cyc, bus_bad, busy_bad, nwords, k;
        logic          err_seen;
        logic          exp_cs, exp_we;
        logic [3:0]    exp_be;
        logic [AW-1:0] exp_addr;
        ndone = 0; done_cyc = 0; bus_bad = 0; busy_bad = 0; err_seen = 1'b0;
        nwords = v.exp_err ? 0 : int'(v.len);
        @(negedge clk);
        src_addr = v.src;
        dst_addr = v.dst;
        length   = v.len;
        start    = 1'b1;
        for (int c = 1; c <= v.exp_done + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = c;
                    err_seen = err;
                end
            end
            if (busy !== (c <= v.exp_done)) busy_bad++;
            exp_cs = 1'b0; exp_we = 1'b0; exp_be = 4'h0; exp_addr = '0;
            if (c <= 3 * nwords) begin
                k = (c - 1) / 3;
                if ((c - 1) % 3 == 0) begin
                    exp_cs   = 1'b1;
                    exp_addr = v.src + AW'(k);
                end else if ((c - 1) % 3 == 2) begin
                    exp_cs   = 1'b1;
                    exp_we   = 1'b1;
                    exp_be   = 4'hF;
                    exp_addr = v.dst + AW'(k);
                end
            end
            if ((avm_chipselect !== exp_cs) || (avm_write !== exp_we) ||
                (avm_byteenable !== exp_be) || (exp_cs && (avm_address !== exp_addr))) begin
                bus_bad++;
            end
        end
        check({v.name, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        check({v.name, "_done_count"}, 64'(ndone), 64'd1);
        check({v.name, "_err"}, 64'(err_seen), 64'(v.exp_err));
        check({v.name, "_busy"}, 64'(busy_bad), 64'd0);
        check({v.name, "_bus_seq"}, 64'(bus_bad), 64'd0);
        ref_copy(v.src, v.dst, nwords);
        mem_compare(v.name);
    endtask

    // Bound the run in case the DUT never completes something.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, busy_cnt, d1, d2;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_val(i);

        add_vec("basic",       'h100,  'h200,  4,     13, 1'b0);
        add_vec("zero_len",    'h50,   'h60,   0,     1,  1'b0);
        add_vec("src_reject",  102399, 'h700,  2,     1,  1'b1);
        add_vec("dst_reject",  'h700,  102399, 2,     1,  1'b1);
        add_vec("src_edge_ok", 102398, 'h300,  2,     7,  1'b0);
        add_vec("dst_edge_ok", 'h320,  102398, 2,     7,  1'b0);
        add_vec("full_reject", 1,      0,      DEPTH, 1,  1'b1);
        add_vec("smear",       'h10,   'h11,   3,     10, 1'b0);
        add_vec("move_down",   'h21,   'h20,   3,     10, 1'b0);
        add_vec("single",      'h30,   'h40,   1,     4,  1'b0);

        #2;
        check("reset_outputs",
              64'({avm_chipselect, avm_write, avm_address, avm_writedata, avm_byteenable,
                   done, err, busy, avm_clken}), 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) load('h100 + i, 32'hA0 + DW'(i));
        for (int i = 0; i < 4; i++) load('h10 + i, DW'(i + 1));

        foreach (vq[i]) run_vec(vq[i]);

        for (int i = 0; i < 4; i++) check("basic_dst_word", 64'(mem_word('h200 + i)), 64'(32'hA0 + i));
        for (int i = 0; i < 4; i++) check("smear_word", 64'(mem_word('h10 + i)), 64'd1);
        for (int i = 0; i < 3; i++)
            check("move_down_word", 64'(mem_word('h20 + i)), 64'(init_val('h21 + i)));

        // Restart attempts while busy and in DONE are dropped; the one after DONE is taken.
        nd = 0; d1 = 0; d2 = 0;
        @(negedge clk);
        src_addr = 'h400; dst_addr = 'h500; length = 4; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                nd++;
                if (nd == 1) d1 = c;
                if (nd == 2) d2 = c;
            end
            if ((c == 5) || (c == 13)) begin
                src_addr = 'h600; dst_addr = 'h610; length = 1; start = 1'b1;
            end
            if (c == 14) begin
                src_addr = 'h420; dst_addr = 'h520; length = 2; start = 1'b1;
            end
        end
        check("restart_done_count", 64'(nd), 64'd2);
        check("restart_first_done", 64'(d1), 64'd13);
        check("restart_second_done", 64'(d2), 64'd21);
        ref_copy('h400, 'h500, 4);
        ref_copy('h420, 'h520, 2);
        mem_compare("restart");

        // Reset during the second word's write cycle.
        @(negedge clk);
        src_addr = 'h800; dst_addr = 'h900; length = 4; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("midop_reset_outputs",
              64'({avm_chipselect, avm_write, avm_address, avm_writedata, avm_byteenable,
                   done, err, busy, avm_clken}), 64'd1);
        ref_copy('h800, 'h900, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0; busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) busy_cnt++;
        end
        check("midop_no_done", 64'(nd), 64'd0);
        check("midop_idle", 64'(busy_cnt), 64'd0);
        check("midop_word0", 64'(mem_word('h900)), 64'(init_val('h800)));
        for (int i = 1; i < 4; i++)
            check("midop_untouched", 64'(mem_word('h900 + i)), 64'(init_val('h900 + i)));
        mem_compare("midop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
